// File: rtl/led_strip_controller_pkg.sv
`default_nettype none
// ============================================================================
// Module      : led_pkg
// Description : Shared states, default WS2812 timing at 50 MHz and GRB packer.
// Revision    : 1.0
// ============================================================================
package led_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        LATCH = 3'd2,
        SEND  = 3'd3,
        GAP   = 3'd4,
        DONE  = 3'd5
    } state_t;

    localparam int c_t0h_cyc   = 20;
    localparam int c_t1h_cyc   = 40;
    localparam int c_bit_cyc   = 63;
    localparam int c_reset_cyc = 3000;

    // {R,G,B} in, {G,R,B} out, each channel dimmed by a right shift
    function automatic logic [23:0] pack_grb(input logic [23:0] rgb, input int unsigned shift);
        logic [7:0] red;
        logic [7:0] grn;
        logic [7:0] blu;
        red = rgb[23:16] >> shift;
        grn = rgb[15:8]  >> shift;
        blu = rgb[7:0]   >> shift;
        return {grn, red, blu};
    endfunction

endpackage
`default_nettype wire

// File: rtl/led_strip_controller_if.sv
`default_nettype none
// ============================================================================
// Module      : led_strip_controller_if
// Description : Frame request, mixer and strip-pin signals of the LED bar.
// Revision    : 1.0
// ============================================================================
interface led_strip_controller_if #(
    parameter int N = 10
);
    logic         frame_start;
    logic [N-1:0] level;
    logic [N-1:0] max_idx;
    logic [N-1:0] mix_contador;
    logic [23:0]  mix_cor;
    logic         led_dout;
    logic         busy;
    logic         frame_done;

    modport master (
        output frame_start, level, max_idx, mix_cor,
        input  mix_contador, led_dout, busy, frame_done
    );

    modport slave (
        input  frame_start, level, max_idx, mix_cor,
        output mix_contador, led_dout, busy, frame_done
    );
endinterface
`default_nettype wire

// File: rtl/led_strip_controller_bit_tx.sv
`default_nettype none
// ============================================================================
// Module      : ws2812_bit_tx
// Description : Serialises one 24-bit GRB word onto the WS2812 line, MSB first.
// Revision    : 1.0
// ============================================================================
module ws2812_bit_tx
    import led_pkg::*;
#(
    parameter int T0H_CYC = c_t0h_cyc,
    parameter int T1H_CYC = c_t1h_cyc,
    parameter int BIT_CYC = c_bit_cyc
)(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_load,
    input  logic [23:0] i_word,
    output logic        o_ready,
    output logic        o_done,
    output logic        o_dout
);
    localparam int              c_tw   = $clog2(BIT_CYC);
    localparam logic [c_tw-1:0] c_t0h  = c_tw'(T0H_CYC);
    localparam logic [c_tw-1:0] c_t1h  = c_tw'(T1H_CYC);
    localparam logic [c_tw-1:0] c_last = c_tw'(BIT_CYC - 1);

    logic [c_tw-1:0] r_timer, w_timer_n;
    logic [23:0]     r_shreg, w_shreg_n;
    logic [4:0]      r_bit,   w_bit_n;
    logic            r_active, w_active_n;
    logic            r_dout,  w_dout_n;

    always_comb begin
        w_timer_n  = r_timer;
        w_shreg_n  = r_shreg;
        w_bit_n    = r_bit;
        w_active_n = r_active;
        if (i_load) begin
            w_timer_n  = '0;
            w_shreg_n  = i_word;
            w_bit_n    = '0;
            w_active_n = 1'b1;
        end else if (r_active) begin
            if (r_timer == c_last) begin
                w_timer_n = '0;
                w_shreg_n = {r_shreg[22:0], 1'b0};
                if (r_bit == 5'd23) begin
                    w_active_n = 1'b0;
                end else begin
                    w_bit_n = r_bit + 5'd1;
                end
            end else begin
                w_timer_n = r_timer + 1'b1;
            end
        end
        // The line level is computed from next-cycle state so the pin is a flop
        w_dout_n = w_active_n && (w_timer_n < (w_shreg_n[23] ? c_t1h : c_t0h));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_timer  <= '0;
            r_shreg  <= '0;
            r_bit    <= '0;
            r_active <= 1'b0;
            r_dout   <= 1'b0;
        end else begin
            r_timer  <= w_timer_n;
            r_shreg  <= w_shreg_n;
            r_bit    <= w_bit_n;
            r_active <= w_active_n;
            r_dout   <= w_dout_n;
        end
    end

    assign o_ready = !r_active;
    assign o_done  = r_active && (r_bit == 5'd23) && (r_timer == c_last);
    assign o_dout  = r_dout;

endmodule
`default_nettype wire

// File: rtl/led_strip_controller.sv
`default_nettype none
// ============================================================================
// Module      : led_strip_controller
// Description : Walks the LED bar per frame, queries the colour mixer per pixel
//               and streams the blanked/dimmed colours to the WS2812 line.
// Revision    : 1.0
// ============================================================================
module led_strip_controller
    import led_pkg::*;
#(
    parameter int          N            = 10,
    parameter int          LOG2_LEDS    = 3,
    parameter int          T0H_CYC      = c_t0h_cyc,
    parameter int          T1H_CYC      = c_t1h_cyc,
    parameter int          BIT_CYC      = c_bit_cyc,
    parameter int          RESET_CYC    = c_reset_cyc,
    parameter int unsigned BRIGHT_SHIFT = 0
)(
    input  logic clock,
    input  logic reset_n,
    led_strip_controller_if.slave bus
);
    localparam int                   c_acc_w    = N + LOG2_LEDS;
    localparam int                   c_gap_w    = $clog2(RESET_CYC);
    localparam logic [LOG2_LEDS-1:0] c_last_pix = LOG2_LEDS'((1 << LOG2_LEDS) - 1);
    localparam logic [c_gap_w-1:0]   c_last_gap = c_gap_w'(RESET_CYC - 1);

    state_t               r_state;
    logic [N-1:0]         r_lvl_snap;
    logic [N-1:0]         r_max_snap;
    logic [c_acc_w-1:0]   r_acc;
    logic [LOG2_LEDS-1:0] r_pix;
    logic [c_gap_w-1:0]   r_gap;
    logic                 r_lit;
    logic [N-1:0]         r_mix_contador;
    logic                 r_busy;
    logic                 r_frame_done;

    logic [N-1:0] w_pos;
    logic         w_load;
    logic [23:0]  w_word;
    logic         w_tx_ready;
    logic         w_tx_done;
    logic         w_tx_dout;

    // acc holds pixel*max_idx with LOG2_LEDS fraction bits; its integer part is the position
    assign w_pos  = r_acc[c_acc_w-1:LOG2_LEDS];
    assign w_load = (r_state == LATCH) && w_tx_ready;
    assign w_word = r_lit ? pack_grb(bus.mix_cor, BRIGHT_SHIFT) : 24'h0;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state        <= IDLE;
            r_lvl_snap     <= '0;
            r_max_snap     <= '0;
            r_acc          <= '0;
            r_pix          <= '0;
            r_gap          <= '0;
            r_lit          <= 1'b0;
            r_mix_contador <= '0;
            r_busy         <= 1'b0;
            r_frame_done   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.frame_start) begin
                        r_lvl_snap <= bus.level;
                        r_max_snap <= bus.max_idx;
                        r_acc      <= '0;
                        r_pix      <= '0;
                        r_busy     <= 1'b1;
                        r_state    <= FETCH;
                    end
                end
                FETCH: begin
                    r_mix_contador <= w_pos;
                    r_lit          <= (w_pos <= r_lvl_snap);
                    r_state        <= LATCH;
                end
                LATCH: begin
                    r_acc   <= r_acc + {{LOG2_LEDS{1'b0}}, r_max_snap};
                    r_state <= SEND;
                end
                SEND: begin
                    if (w_tx_done) begin
                        if (r_pix == c_last_pix) begin
                            r_gap   <= '0;
                            r_state <= GAP;
                        end else begin
                            r_pix   <= r_pix + 1'b1;
                            r_state <= FETCH;
                        end
                    end
                end
                GAP: begin
                    if (r_gap == c_last_gap) begin
                        r_frame_done <= 1'b1;
                        r_state      <= DONE;
                    end else begin
                        r_gap <= r_gap + 1'b1;
                    end
                end
                DONE: begin
                    r_frame_done <= 1'b0;
                    r_busy       <= 1'b0;
                    r_state      <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    ws2812_bit_tx #(
        .T0H_CYC (T0H_CYC),
        .T1H_CYC (T1H_CYC),
        .BIT_CYC (BIT_CYC)
    ) u_bit_tx (
        .clk     (clock),
        .rst_n   (reset_n),
        .i_load  (w_load),
        .i_word  (w_word),
        .o_ready (w_tx_ready),
        .o_done  (w_tx_done),
        .o_dout  (w_tx_dout)
    );

    assign bus.mix_contador = r_mix_contador;
    assign bus.led_dout     = w_tx_dout;
    assign bus.busy         = r_busy;
    assign bus.frame_done   = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_led_strip_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_led_strip_controller
// Description : Frame-level bench: decodes the WS2812 line and scores each pixel.
// Revision    : 1.0
// ============================================================================
module tb_led_strip_controller;

    localparam int c_frame_busy = 8 * (2 + 24 * 63) + 3000 + 1;

    typedef struct {
        int         level;
        int         max_idx;
        logic [7:0] lit_mask;
        bit         mid_start;
        bit         mid_change;
        bit         done_start;
    } vec_t;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    always #10 clock = ~clock;

    led_strip_controller_if #(.N(10)) bus();

    led_strip_controller #(
        .N            (10),
        .LOG2_LEDS    (3),
        .T0H_CYC      (20),
        .T1H_CYC      (40),
        .BIT_CYC      (63),
        .RESET_CYC    (3000),
        .BRIGHT_SHIFT (0)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    // Stand-in colour mixer: red->yellow up to mid (511), then yellow->green-ish
    function automatic logic [23:0] mix_model(input logic [9:0] c);
        int ci, r, g, b;
        ci = int'(c);
        if (ci <= 511) begin
            r = 255; g = (ci * 255) / 511; b = 0;
        end else begin
            r = 255 - ((ci - 511) * 255) / 512; g = 255; b = (ci - 511) / 2;
        end
        return {r[7:0], g[7:0], b[7:0]};
    endfunction

    function automatic logic [23:0] to_grb(input logic [23:0] rgb);
        return {rgb[15:8], rgb[23:16], rgb[7:0]};
    endfunction

    assign bus.mix_cor = mix_model(bus.mix_contador);

    int checks = 0;
    int errors = 0;
    logic [23:0] exp_word_q[$];
    logic [9:0]  exp_pos_q[$];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h, want %0h", name, got, want);
        end
    endtask

    // Line decoder and scoreboard
    int          m_hi = 0, m_lo = 1000, m_last_hi = 0, m_nbits = 0;
    logic        m_prev = 1'b0;
    logic [23:0] m_word = '0;

    always @(negedge clock) begin
        if (!reset_n) begin
            m_hi = 0; m_lo = 1000; m_nbits = 0; m_prev = 1'b0; m_word = '0;
        end else begin
            if (bus.led_dout) begin
                if (!m_prev) begin
                    if (m_lo < 200)
                        check("bit_low_time", m_lo, 63 - m_last_hi + ((m_nbits == 0) ? 2 : 0));
                    if (m_nbits == 0) begin
                        checks++;
                        if (exp_pos_q.size() == 0) begin
                            errors++;
                            $display("FAIL pixel_pos: got %0d, want nothing (no pixel expected)", bus.mix_contador);
                        end else begin
                            logic [9:0] ep;
                            ep = exp_pos_q.pop_front();
                            if (bus.mix_contador !== ep) begin
                                errors++;
                                $display("FAIL pixel_pos: got %0d, want %0d", bus.mix_contador, ep);
                            end
                        end
                    end
                    m_hi = 0;
                end
                m_hi++;
            end else begin
                if (m_prev) begin
                    checks++;
                    if (m_hi != 20 && m_hi != 40) begin
                        errors++;
                        $display("FAIL bit_high_time: got %0d, want 20 or 40", m_hi);
                    end
                    m_word    = {m_word[22:0], (m_hi == 40)};
                    m_last_hi = m_hi;
                    m_nbits++;
                    if (m_nbits == 24) begin
                        m_nbits = 0;
                        checks++;
                        if (exp_word_q.size() == 0) begin
                            errors++;
                            $display("FAIL pixel_word: got %06h, want nothing (no pixel expected)", m_word);
                        end else begin
                            logic [23:0] ew;
                            ew = exp_word_q.pop_front();
                            if (m_word !== ew) begin
                                errors++;
                                $display("FAIL pixel_word: got %06h, want %06h", m_word, ew);
                            end
                        end
                    end
                    m_lo = 0;
                end
                m_lo++;
            end
            m_prev = bus.led_dout;
        end
    end

    task automatic push_frame(input int lvl_unused, input int max_idx, input logic [7:0] mask);
        for (int p = 0; p < 8; p++) begin
            logic [9:0] pos;
            int         acc;
            acc = p * max_idx;
            pos = 10'(acc >> 3);
            exp_pos_q.push_back(pos);
            exp_word_q.push_back(mask[p] ? to_grb(mix_model(pos)) : 24'h0);
        end
        if (lvl_unused < 0) $display("note: negative level");
    endtask

    task automatic start_frame(input int lvl, input int mx);
        bus.level       = 10'(lvl);
        bus.max_idx     = 10'(mx);
        bus.frame_start = 1'b1;
        @(negedge clock);
        bus.frame_start = 1'b0;
    endtask

    task automatic run_frame(input vec_t v);
        int cnt, dcnt;
        bit ended;
        push_frame(v.level, v.max_idx, v.lit_mask);
        start_frame(v.level, v.max_idx);
        cnt = 0; dcnt = 0; ended = 1'b0;
        for (int k = 0; k < 20000; k++) begin
            if (!bus.busy) begin
                ended = 1'b1;
                break;
            end
            cnt++;
            if (bus.frame_done) dcnt++;
            bus.frame_start = (v.mid_start && cnt == 100) || (v.done_start && bus.frame_done);
            if (v.mid_change && cnt == 3000) begin
                bus.level   = 10'd1023;
                bus.max_idx = 10'd0;
            end
            @(negedge clock);
        end
        bus.frame_start = 1'b0;
        check("frame_ended", ended, 1'b1);
        check("busy_cycles", cnt, c_frame_busy);
        check("frame_done_cycles", dcnt, 1);
        check("words_left", exp_word_q.size(), 0);
        @(negedge clock);
        check("idle_after_done", bus.busy, 1'b0);
    endtask

    initial begin
        vec_t vecs[4];
        bit   seen;
        vecs[0] = '{level: 1023, max_idx: 1023, lit_mask: 8'hFF, mid_start: 1'b1, mid_change: 1'b0, done_start: 1'b0};
        vecs[1] = '{level: 300,  max_idx: 1023, lit_mask: 8'h07, mid_start: 1'b0, mid_change: 1'b1, done_start: 1'b0};
        vecs[2] = '{level: 0,    max_idx: 0,    lit_mask: 8'hFF, mid_start: 1'b0, mid_change: 1'b0, done_start: 1'b1};
        vecs[3] = '{level: 894,  max_idx: 1023, lit_mask: 8'h7F, mid_start: 1'b0, mid_change: 1'b0, done_start: 1'b0};

        bus.frame_start = 1'b0;
        bus.level       = '0;
        bus.max_idx     = '0;
        reset_n         = 1'b0;
        repeat (3) @(negedge clock);
        check("rst_led_dout", bus.led_dout, 1'b0);
        check("rst_busy", bus.busy, 1'b0);
        check("rst_frame_done", bus.frame_done, 1'b0);
        check("rst_mix_contador", bus.mix_contador, 10'd0);
        reset_n = 1'b1;
        repeat (2) @(negedge clock);
        check("idle_busy", bus.busy, 1'b0);

        for (int i = 0; i < 4; i++) begin
            run_frame(vecs[i]);
            if (i == 1) begin
                // Abort a frame in the high phase of pixel 3, bit 5
                push_frame(1023, 1023, 8'hFF);
                start_frame(1023, 1023);
                repeat (3 * 1514 + 2 + 5 * 63 + 10) @(negedge clock);
                check("pre_reset_dout", bus.led_dout, 1'b1);
                reset_n = 1'b0;
                #1;
                check("abort_led_dout", bus.led_dout, 1'b0);
                check("abort_busy", bus.busy, 1'b0);
                check("abort_mix_contador", bus.mix_contador, 10'd0);
                repeat (2) @(negedge clock);
                exp_word_q.delete();
                exp_pos_q.delete();
                reset_n = 1'b1;
                seen = 1'b0;
                repeat (5000) begin
                    @(negedge clock);
                    if (bus.led_dout || bus.busy) seen = 1'b1;
                end
                check("quiet_after_reset", seen, 1'b0);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/led_strip_controller.md
Name: led_strip_controller

Overview:
- Frame sequencer for the game's WS2812 LED bar. On each frame request it walks every pixel in turn and computes that pixel's position value.
- For each pixel it drives the position into the external led_color_mixxer (contador input) and captures the resulting 24-bit colour.
- Pixels above the current level are blanked. Each colour is serialised onto one WS2812 data line in GRB order, MSB first.
- Sits between the game-state logic (which supplies level and max_idx) and the strip pin. It owns the shared mixer's contador input.

Parameters:
- N, 10, width of level / max_idx / mix_contador; must match the mixer's N.
- LOG2_LEDS, 3, log2 of pixel count; NUM_LEDS = 1<<LOG2_LEDS.
- T0H_CYC, 20, high time of a '0' bit in clock cycles (0.4 us at 50 MHz).
- T1H_CYC, 40, high time of a '1' bit in clock cycles (0.8 us).
- BIT_CYC, 63, total cycles per bit (~1.25 us).
- RESET_CYC, 3000, low latch gap after the last bit (60 us).
- BRIGHT_SHIFT, 0, right shift applied to each 8-bit channel before transmission.

Ports:
- clock, input, 1, system clock.
- reset_n, input, 1, asynchronous active-low reset.
- frame_start, input, 1, one-cycle request to send a frame; ignored while busy.
- level, input, N, current fill level; sampled on accepted frame_start.
- max_idx, input, N, full-scale index; sampled on accepted frame_start.
- mix_contador, output, N, drives the mixer's contador.
- mix_cor, input, 24, mixer cor_led {R,G,B}; combinational from mix_contador.
- led_dout, output, 1, WS2812 serial data.
- busy, output, 1, high from the cycle after an accepted frame_start until frame_done.
- frame_done, output, 1, one-cycle pulse at the end of the latch gap.

Behaviour:
- Reset (async, reset_n=0): state IDLE; led_dout=0, busy=0, frame_done=0, mix_contador=0; all counters and snapshots cleared. Reset mid-frame aborts at once and leaves the line low. After reset release, nothing is transmitted until the next frame_start.
- IDLE: frame_start=1 latches lvl_snap<=level, max_snap<=max_idx, acc<=0, pix<=0, and moves to FETCH. busy rises the next cycle.
- FETCH (1 cycle):
  - pos = acc >> LOG2_LEDS, with acc of width N+LOG2_LEDS.
  - mix_contador <= pos (registered).
  - lit <= (pos <= lvl_snap), unsigned compare.
- LATCH (1 cycle):
  - Sample mix_cor, with R=[23:16], G=[15:8], B=[7:0].
  - Apply each channel >> BRIGHT_SHIFT.
  - shreg <= lit ? {G,R,B} : 24'h0.
  - bit <= 0, timer <= 0.
  - acc <= acc + max_snap.
- SEND (24*BIT_CYC cycles):
  - led_dout = (timer < (shreg[23] ? T1H_CYC : T0H_CYC)).
  - timer counts 0..BIT_CYC-1. At wrap, shreg shifts left and bit increments.
  - After bit 23 completes: if pix==NUM_LEDS-1, go to GAP; else pix++ and go to FETCH.
- Inter-pixel overhead: exactly 2 low cycles (FETCH+LATCH) extend the previous bit's low phase. This is within WS2812 tolerance.
- GAP: led_dout=0 for RESET_CYC cycles, then DONE.
- DONE (1 cycle): frame_done=1, busy drops, return to IDLE. frame_start in this cycle is ignored.
- Frame length from the accepted frame_start: busy is high for NUM_LEDS*(2+24*BIT_CYC)+RESET_CYC+1 cycles.
- led_dout is a registered output, with no glitches between phases.
- Boundaries:
  - max_idx=0: every pos=0, so all pixels are lit iff level>=0 (always); all show mixer(0).
  - level >= max_idx: all pixels are lit.
  - The acc add never overflows: acc_max = (NUM_LEDS-1)*(2^N-1).
  - level/max_idx changes during a frame have no effect, because the snapshots are used.

Decomposition:
- Package led_pkg holds:
  - state enum {IDLE, FETCH, LATCH, SEND, GAP, DONE};
  - default timing constants (T0H/T1H/BIT/RESET cycles at 50 MHz);
  - a function pack_grb(rgb, shift).
- One natural sub-module, ws2812_bit_tx:
  - contains the timer, 24-bit shift register and led_dout generation;
  - has a load/ready handshake (load pulse with 24-bit word; done pulse after the 24th bit).
- The controller keeps the pixel walk, acc, snapshots and GAP/DONE sequencing.

Test Plan:
- Reset: hold reset_n=0 → led_dout=0, busy=0, frame_done=0, mix_contador=0. Assert reset_n=0 mid-bit → led_dout=0 in the same cycle.
- Full bar: level=1023, max_idx=1023, real led_color_mixxer (mid_idx=511) →
  - mix_contador sequence is 0,127,255,383,511,639,767,895;
  - pixel 4 is sent as GRB FF FF 00.
- Partial bar: level=300, max_idx=1023 → pixels 0..2 lit; pixels 3..7 are 24 bits of 20-high/43-low each.
- Bit timing: pixel 0 colour R=FF,G=00,B=00 → first 8 bits each 20 high/43 low; bits 8..15 each 40 high/23 low; 2 extra low cycles before pixel 1.
- Frame handshake: frame_start, then frame_start again 100 cycles later →
  - second request ignored;
  - busy high exactly 8*1514+3000+1=15113 cycles;
  - frame_done high exactly 1 cycle;
  - a new frame_start after DONE is accepted.
- Snapshot/reset: change level mid-frame → output unchanged. Reset during pixel 3 bit 5, release, wait 5000 cycles → led_dout stays 0 and busy=0 until the next frame_start.
